// File: rtl/cmd_dispatch.sv
// ---------------------------------------------------------------------------
// cmd_dispatch
//   Sequencer behind the 3-byte UART command wrapper. It takes a complete
//   command when the wrapper raises cmd_rdy, clears that flag, updates the
//   flight setpoints, runs the inertial calibration handshake, and returns a
//   1-byte ack (A5) / nack (EE) through the wrapper's response path. It also
//   owns the comm-loss watchdog that zeroes the setpoints when no command
//   arrives for 2**WDOG_W-1 cycles.
//
// Handshakes (all pulse outputs are registered and 1 cycle wide):
//   cmd_rdy is a level owned by the wrapper and is consumed only in IDLE;
//   the clr_cmd_rdy pulse marks the accept cycle. send_resp starts a transmit
//   of resp, which stays stable until resp_sent is seen. strt_cal starts a
//   calibration, and cal_done (any cycle while waiting) completes it.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cmd_rdy/cmd/data  command from the wrapper
//   clr_cmd_rdy       clears the wrapper's cmd_rdy
//   resp/send_resp    response byte and its transmit start pulse
//   resp_sent         wrapper transmit complete
//   cal_done          inertial calibration complete
//   strt_cal          starts inertial calibration
//   inertial_cal      high while calibration is in progress
//   motors_off        forces motors off (set at reset until a good calibrate)
//   d_ptch/d_roll/d_yaw/thrst  flight setpoints
//   wdog_trip         watchdog expired; setpoints held at zero
// ---------------------------------------------------------------------------
module cmd_dispatch #(
    parameter int WDOG_W  = 26,
    parameter int CAL_TMO = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    input  logic        cal_done,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        wdog_trip
);

    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    // Calibration counter counts 0..CAL_TMO-1; the last value is the timeout.
    localparam int              CAL_W    = (CAL_TMO > 1) ? $clog2(CAL_TMO) : 1;
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_TMO - 1);

    // Watchdog saturates at all-ones; the trip fires on the step into it.
    localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAL_WAIT = 2'd1,
        SEND     = 2'd2,
        WAIT_TX  = 2'd3
    } state_t;

    state_t            state;
    logic              tx_first;   // first WAIT_TX cycle: resp_sent may be stale
    logic [CAL_W-1:0]  cal_cnt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              accept;

    assign accept = (state == IDLE) && cmd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_first     <= 1'b0;
            cal_cnt      <= '0;
            wdog_cnt     <= '0;
            clr_cmd_rdy  <= 1'b0;
            resp         <= 8'h00;
            send_resp    <= 1'b0;
            strt_cal     <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            d_ptch       <= '0;
            d_roll       <= '0;
            d_yaw        <= '0;
            thrst        <= '0;
            wdog_trip    <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;

            // Watchdog. An accept on the expiry cycle wins: the counter
            // clears and the setpoints are not zeroed. While tripped the
            // setpoints stay zero because only an accept writes them, and an
            // accept also clears the trip.
            if (accept) begin
                wdog_cnt  <= '0;
                wdog_trip <= 1'b0;
            end else if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
                if (wdog_cnt == WDOG_LAST) begin
                    wdog_trip <= 1'b1;
                    d_ptch    <= '0;
                    d_roll    <= '0;
                    d_yaw     <= '0;
                    thrst     <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        clr_cmd_rdy <= 1'b1;
                        resp        <= ACK;
                        state       <= SEND;
                        case (cmd)
                            OP_SET_PTCH:  d_ptch <= data;
                            OP_SET_ROLL:  d_roll <= data;
                            OP_SET_YAW:   d_yaw  <= data;
                            OP_SET_THRST: thrst  <= data[8:0];
                            OP_CALIBRATE: begin
                                strt_cal     <= 1'b1;
                                inertial_cal <= 1'b1;
                                cal_cnt      <= '0;
                                state        <= CAL_WAIT;
                            end
                            OP_EMER_LAND: begin
                                d_ptch <= '0;
                                d_roll <= '0;
                                d_yaw  <= '0;
                                thrst  <= '0;
                            end
                            OP_MTRS_OFF:  motors_off <= 1'b1;
                            default:      resp <= NACK;
                        endcase
                    end
                end

                CAL_WAIT: begin
                    // cal_done is tested first so it wins on the timeout cycle.
                    if (cal_done) begin
                        inertial_cal <= 1'b0;
                        motors_off   <= 1'b0;
                        resp         <= ACK;
                        state        <= SEND;
                    end else if (cal_cnt == CAL_LAST) begin
                        inertial_cal <= 1'b0;
                        resp         <= NACK;
                        state        <= SEND;
                    end else begin
                        cal_cnt <= cal_cnt + CAL_W'(1);
                    end
                end

                SEND: begin
                    send_resp <= 1'b1;
                    tx_first  <= 1'b1;
                    state     <= WAIT_TX;
                end

                WAIT_TX: begin
                    tx_first <= 1'b0;
                    if (!tx_first && resp_sent) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_cmd_dispatch
//   Directed and randomized transactions against cmd_dispatch (WDOG_W=6,
//   CAL_TMO=64). The reference model tracks setpoints per command, the
//   expected response bytes in a queue, and the watchdog as "cycles since the
//   last accepted command".
// ---------------------------------------------------------------------------
module tb_cmd_dispatch;

    localparam int WDOG_W  = 6;
    localparam int CAL_TMO = 64;
    localparam int WD_LIM  = (1 << WDOG_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        resp_sent = 1'b0;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, wdog_trip;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_dispatch #(.WDOG_W(WDOG_W), .CAL_TMO(CAL_TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .cal_done(cal_done), .strt_cal(strt_cal),
        .inertial_cal(inertial_cal), .motors_off(motors_off),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
        .wdog_trip(wdog_trip)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_moff;
    int          last_acc;
    bit          cur_cal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_moff = 1'b1;
        exp_q.delete();
        cur_cal = 0;
    endtask

    // Watchdog expires WD_LIM cycles after the last accept.
    task automatic model_wdog();
        if (cyc - last_acc >= WD_LIM) begin
            m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
        end
    endtask

    // Called on the cycle the accept becomes visible.
    task automatic model_accept(input logic [7:0] c, input logic [15:0] d);
        if (cyc - last_acc > WD_LIM) begin
            m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
        end
        last_acc = cyc;
        case (c)
            8'h02: m_ptch  = d;
            8'h03: m_roll  = d;
            8'h04: m_yaw   = d;
            8'h05: m_thrst = d[8:0];
            8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
            8'h08: m_moff  = 1'b1;
            default: ;
        endcase
        if (c != 8'h06) exp_q.push_back((c >= 8'h02 && c <= 8'h08) ? 8'hA5 : 8'hEE);
    endtask

    task automatic check_state();
        model_wdog();
        check("d_ptch", d_ptch, m_ptch);
        check("d_roll", d_roll, m_roll);
        check("d_yaw", d_yaw, m_yaw);
        check("thrst", thrst, m_thrst);
        check("motors_off", motors_off, m_moff);
        check("wdog_trip", wdog_trip, (cyc - last_acc >= WD_LIM));
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_txn(input logic [7:0] c, input logic [15:0] d);
        int k = 0;
        cmd = c; data = d; cmd_rdy = 1'b1;
        do begin
            step();
            k++;
        end while (!clr_cmd_rdy && k < 200);
        check("accept_latency", k, 1);
        cmd_rdy = 1'b0;
        model_accept(c, d);
        cur_cal = (c == 8'h06);
        check("wdog_clear_on_accept", wdog_trip, 0);
        check("strt_cal", strt_cal, cur_cal);
        check("inertial_cal_start", inertial_cal, cur_cal);
        check_state();
    endtask

    // cal_d: cycle index (after strt_cal is seen) on which cal_done is
    // presented; negative means never.
    task automatic finish_txn(input int cal_d, input bit stale, input int tx_d);
        int k = 0;
        int ic = inertial_cal ? 1 : 0;
        int sc = 0;
        int exp_ic = 0;
        bit busy_clr = 0;
        bit ack;
        logic [7:0] exp_r;
        if (cur_cal) begin
            ack = (cal_d >= 0) && (cal_d <= CAL_TMO - 1);
            exp_q.push_back(ack ? 8'hA5 : 8'hEE);
            if (ack) m_moff = 1'b0;
            exp_ic = ack ? cal_d + 1 : CAL_TMO;
        end
        while (!send_resp && k < 300) begin
            cal_done = cur_cal && (k == cal_d);
            step();
            k++;
            if (inertial_cal) ic++;
            if (strt_cal) sc++;
            if (clr_cmd_rdy) busy_clr = 1;
        end
        cal_done = 1'b0;
        check("send_resp_seen", send_resp, 1);
        check("inertial_cal_span", ic, exp_ic);
        check("strt_cal_single", sc, 0);
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check("resp", resp, exp_r);
        resp_sent = stale;
        step();
        resp_sent = 1'b0;
        if (clr_cmd_rdy) busy_clr = 1;
        check("send_resp_pulse", send_resp, 0);
        for (int i = 0; i < tx_d; i++) begin
            step();
            if (clr_cmd_rdy) busy_clr = 1;
        end
        check("resp_hold", resp, exp_r);
        resp_sent = 1'b1;
        step();
        resp_sent = 1'b0;
        if (clr_cmd_rdy) busy_clr = 1;
        check("no_accept_busy", busy_clr, 0);
        check_state();
        cur_cal = 0;
    endtask

    task automatic do_txn(input logic [7:0] c, input logic [15:0] d, input int cal_d,
                          input bit stale, input int tx_d);
        start_txn(c, d);
        finish_txn(cal_d, stale, tx_d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        model_reset();
        last_acc = 0;
        step();
        step();
        // Reset values while rst_n is low.
        check("rst_motors_off", motors_off, 1);
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_send", send_resp, 0);
        check("rst_strt", strt_cal, 0);
        check("rst_inertial", inertial_cal, 0);
        check("rst_resp", resp, 0);
        check("rst_wdog", wdog_trip, 0);
        check("rst_thrst", thrst, 0);
        rst_n = 1'b1;
        last_acc = cyc;

        // 1. thrust keeps only data[8:0]
        do_txn(8'h05, 16'hFE80, -1, 1'b1, 2);
        check("thrst_low9", thrst, 9'h080);

        // 2. setpoints then emergency land
        do_txn(8'h02, 16'h8001, -1, 1'b0, 0);
        do_txn(8'h03, 16'h1234, -1, 1'b1, 1);
        do_txn(8'h04, 16'hABCD, -1, 1'b0, 3);
        do_txn(8'h07, 16'h5555, -1, 1'b0, 1);

        // 4. calibrate timeout: nack, motors stay off (watchdog also trips)
        do_txn(8'h06, 16'h0000, -1, 1'b0, 1);
        // 3. calibrate completes after a wait: ack, motors enabled
        do_txn(8'h06, 16'h0000, 40, 1'b1, 2);
        do_txn(8'h08, 16'h0000, -1, 1'b0, 0);
        // cal_done on the terminal-count cycle wins
        do_txn(8'h06, 16'h0000, CAL_TMO - 1, 1'b0, 0);
        do_txn(8'h02, 16'h7FFF, -1, 1'b0, 0);

        // 5. unknown opcode, second command held during WAIT_TX
        start_txn(8'h33, 16'hFFFF);
        cmd = 8'h03; data = 16'h0F0F; cmd_rdy = 1'b1;
        finish_txn(-1, 1'b1, 3);
        start_txn(8'h03, 16'h0F0F);
        finish_txn(-1, 1'b0, 1);

        // 6. watchdog expiry with no traffic, then a set clears it
        while (cyc < last_acc + WD_LIM - 1) step();
        check_state();
        step();
        check_state();
        check("wdog_tripped", wdog_trip, 1);
        do_txn(8'h04, 16'h0010, -1, 1'b0, 1);
        check("d_yaw_after_trip", d_yaw, 16'h0010);

        // Reset in the middle of a calibration drops the pending response.
        start_txn(8'h06, 16'h0000);
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_inertial", inertial_cal, 0);
        check("midrst_motors_off", motors_off, 1);
        check("midrst_d_yaw", d_yaw, 0);
        step();
        rst_n = 1'b1;
        last_acc = cyc;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (send_resp) seen = 1;
        end
        check("midrst_no_resp", seen, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic [7:0] c;
            int gap;
            sel = $urandom_range(0, 7);
            if (sel == 7) begin
                c = 8'($urandom_range(0, 255));
                if (c >= 8'h02 && c <= 8'h08) c = 8'hC3;
            end else begin
                c = 8'(8'h02 + sel);
            end
            gap = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) step();
            do_txn(c, 16'($urandom), $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
